// File: rtl/gameover_screen.sv
`default_nettype none
// ============================================================================
//  Module      : gameover_screen
//  Description : Final pixel compositor with fade-out, blinking game-over
//                banner, debounced start button and restart pulse.
//  Revision    : 1.0  initial release
// ============================================================================
module gameover_screen #(
    parameter int FADE_FRAMES_PER_STEP = 8,
    parameter int BLINK_FRAMES         = 30,
    parameter int RESTART_CYCLES       = 16,
    parameter int DEBOUNCE_CYCLES      = 1000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [9:0]  x,
    input  logic [9:0]  y,
    input  logic        video_on,
    input  logic [11:0] background_rgb,
    input  logic        sprite_on,
    input  logic [11:0] sprite_rgb,
    input  logic        gameover,
    input  logic        btn_start,
    output logic [11:0] rgb_out,
    output logic        game_reset,
    output logic [1:0]  state_o
);

    localparam int c_FADE_W  = (FADE_FRAMES_PER_STEP > 1) ? $clog2(FADE_FRAMES_PER_STEP) : 1;
    localparam int c_BLINK_W = (BLINK_FRAMES > 1)         ? $clog2(BLINK_FRAMES)         : 1;
    localparam int c_RST_W   = (RESTART_CYCLES > 1)       ? $clog2(RESTART_CYCLES)       : 1;
    localparam int c_DB_W    = (DEBOUNCE_CYCLES > 1)      ? $clog2(DEBOUNCE_CYCLES)      : 1;

    localparam logic [c_FADE_W-1:0]  c_FADE_LAST  = c_FADE_W'(FADE_FRAMES_PER_STEP - 1);
    localparam logic [c_BLINK_W-1:0] c_BLINK_LAST = c_BLINK_W'(BLINK_FRAMES - 1);
    localparam logic [c_RST_W-1:0]   c_RST_LAST   = c_RST_W'(RESTART_CYCLES - 1);
    localparam logic [c_DB_W-1:0]    c_DB_LAST    = c_DB_W'(DEBOUNCE_CYCLES - 1);

    localparam logic [1:0] c_ST_PLAY    = 2'd0;
    localparam logic [1:0] c_ST_FADE    = 2'd1;
    localparam logic [1:0] c_ST_OVER    = 2'd2;
    localparam logic [1:0] c_ST_RESTART = 2'd3;

    logic [1:0]           state_q, state_d;
    logic [1:0]           lvl_q, lvl_d;
    logic [c_FADE_W-1:0]  fcnt_q, fcnt_d;
    logic [c_BLINK_W-1:0] bcnt_q, bcnt_d;
    logic                 phase_q, phase_d;
    logic [c_RST_W-1:0]   rcnt_q, rcnt_d;
    logic [11:0]          rgb_q, rgb_d;
    logic                 game_reset_q, game_reset_d;
    logic                 origin_q;
    logic                 sync1_q, sync2_q;
    logic [c_DB_W-1:0]    db_cnt_q, db_cnt_d;
    logic                 db_level_q, db_level_d;

    logic        w_origin, w_tick, w_db_flip, w_press;
    logic        w_in_banner, w_border;
    logic [11:0] w_pix, w_faded, w_banner;

    assign w_origin = (x == 10'd0) && (y == 10'd0);
    assign w_tick   = w_origin && !origin_q;

    assign w_pix   = !video_on ? 12'h000 : (sprite_on ? sprite_rgb : background_rgb);
    assign w_faded = {w_pix[11:8] >> lvl_q, w_pix[7:4] >> lvl_q, w_pix[3:0] >> lvl_q};

    assign w_in_banner = video_on && (x >= 10'd240) && (x <= 10'd399) &&
                         (y >= 10'd200) && (y <= 10'd279);
    assign w_border    = (x < 10'd242) || (x > 10'd397) || (y < 10'd202) || (y > 10'd277);
    assign w_banner    = !w_in_banner ? 12'h000 :
                         w_border     ? 12'hFFF :
                         phase_q      ? 12'hF00 : 12'h400;

    // Level flips once the synced button has disagreed with it for DEBOUNCE_CYCLES edges.
    assign w_db_flip  = (sync2_q != db_level_q) && (db_cnt_q == c_DB_LAST);
    assign w_press    = w_db_flip && !db_level_q;
    assign db_level_d = db_level_q ^ w_db_flip;
    assign db_cnt_d   = ((sync2_q == db_level_q) || w_db_flip) ? '0 : db_cnt_q + 1'b1;

    always_comb begin
        state_d = state_q;
        lvl_d   = lvl_q;
        fcnt_d  = fcnt_q;
        bcnt_d  = bcnt_q;
        phase_d = phase_q;
        rcnt_d  = rcnt_q;
        rgb_d   = 12'h000;
        case (state_q)
            c_ST_PLAY: begin
                rgb_d = w_pix;
                if (gameover) begin
                    state_d = c_ST_FADE;
                    lvl_d   = 2'd0;
                    fcnt_d  = '0;
                    // A tick coinciding with entry counts as the first fade frame.
                    if (w_tick) begin
                        if (c_FADE_LAST == '0) lvl_d = 2'd1;
                        else                   fcnt_d = c_FADE_W'(1);
                    end
                end
            end
            c_ST_FADE: begin
                rgb_d = w_faded;
                if (w_tick) begin
                    if (fcnt_q == c_FADE_LAST) begin
                        fcnt_d = '0;
                        if (lvl_q == 2'd3) begin
                            state_d = c_ST_OVER;
                            bcnt_d  = '0;
                            phase_d = 1'b1;
                        end else begin
                            lvl_d = lvl_q + 2'd1;
                        end
                    end else begin
                        fcnt_d = fcnt_q + 1'b1;
                    end
                end
            end
            c_ST_OVER: begin
                rgb_d = w_banner;
                if (w_press) begin
                    state_d = c_ST_RESTART;
                    rcnt_d  = '0;
                end else if (w_tick) begin
                    if (bcnt_q == c_BLINK_LAST) begin
                        bcnt_d  = '0;
                        phase_d = !phase_q;
                    end else begin
                        bcnt_d = bcnt_q + 1'b1;
                    end
                end
            end
            default: begin
                if (rcnt_q == c_RST_LAST) state_d = c_ST_PLAY;
                else                      rcnt_d  = rcnt_q + 1'b1;
            end
        endcase
    end

    assign game_reset_d = (state_d == c_ST_RESTART);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= c_ST_PLAY;
            lvl_q        <= 2'd0;
            fcnt_q       <= '0;
            bcnt_q       <= '0;
            phase_q      <= 1'b1;
            rcnt_q       <= '0;
            rgb_q        <= 12'h000;
            game_reset_q <= 1'b0;
            origin_q     <= 1'b0;
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            db_cnt_q     <= '0;
            db_level_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            lvl_q        <= lvl_d;
            fcnt_q       <= fcnt_d;
            bcnt_q       <= bcnt_d;
            phase_q      <= phase_d;
            rcnt_q       <= rcnt_d;
            rgb_q        <= rgb_d;
            game_reset_q <= game_reset_d;
            origin_q     <= w_origin;
            sync1_q      <= btn_start;
            sync2_q      <= sync1_q;
            db_cnt_q     <= db_cnt_d;
            db_level_q   <= db_level_d;
        end
    end

    assign rgb_out    = rgb_q;
    assign game_reset = game_reset_q;
    assign state_o    = state_q;

endmodule
`default_nettype wire

// File: doc/gameover_screen.md
# gameover_screen

Final pixel compositor and end-of-game sequencer, directly downstream of the lives/background stage. Merges the arena background colour with the sprite layer into the colour driven to the VGA DAC. When `gameover` asserts, it fades the picture to black over several frames, shows a blinking banner, and waits for a debounced start press. It then issues a fixed-length `game_reset` pulse that restarts the game logic.

## Interface
Parameters:
- `FADE_FRAMES_PER_STEP`, 8: frames held at each fade level.
- `BLINK_FRAMES`, 30: frames per banner blink half-period.
- `RESTART_CYCLES`, 16: clk cycles `game_reset` stays high.
- `DEBOUNCE_CYCLES`, 1000000: consecutive stable cycles needed to accept a button level change.

Ports:
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high.
- `x`, `y`  in  10 each  current pixel coordinates from the sync generator.
- `video_on`  in  1  high inside the visible area.
- `background_rgb`  in  12  arena/background colour from the lives stage.
- `sprite_on`  in  1  a sprite pixel is present.
- `sprite_rgb`  in  12  sprite colour.
- `gameover`  in  1  lives exhausted (level).
- `btn_start`  in  1  raw, asynchronous push button, active-high.
- `rgb_out`  out  12  registered pixel colour, 4 bits per channel {R,G,B}.
- `game_reset`  out  1  registered restart pulse to game logic.
- `state_o`  out  2  current state (PLAY=0, FADE=1, OVER=2, RESTART=3).

## Operation
- Reset values: state PLAY, `rgb_out`=0, `game_reset`=0, fade level 0, all counters 0, blink phase 1, debounced button level 0, frame-tick history 0.
- Frame tick: a single-cycle pulse on the first clk cycle where x==0 and y==0, detected against a registered copy of that condition. Multi-cycle pixel periods therefore give exactly one tick per frame.
- Composite pixel `c`: 0 if `video_on`=0; else `sprite_rgb` if `sprite_on`; else `background_rgb`.
- Button path:
  - 2-flop synchroniser, then a counter that clears whenever the synced value equals the debounced level.
  - When the counter reaches DEBOUNCE_CYCLES-1 the debounced level flips.
  - A press is the 0→1 edge of the debounced level.
  - The debouncer runs in all states; presses outside OVER are discarded.
- PLAY:
  - `rgb_out`←`c`.
  - `gameover`=1 → FADE (level 0, frame count 0).
- FADE:
  - Each channel of `c` is shifted right by the fade level (0..3), i.e. 4-bit logical shift.
  - On each tick, frame count increments; at FADE_FRAMES_PER_STEP-1 the count clears and the level increments.
  - The level increment from 3 moves to OVER instead, with blink count 0 and phase 1.
  - `gameover` deasserting mid-fade is ignored.
- OVER:
  - Banner region is x 240..399, y 200..279 inclusive, with `video_on`=1.
  - Banner border (outer 2 pixels): 12'hFFF. Banner interior: 12'hF00 when phase=1, 12'h400 when phase=0.
  - Everything outside the banner is 0.
  - Blink count advances on ticks; at BLINK_FRAMES-1 it clears and the phase toggles.
  - Press → RESTART.
- RESTART:
  - `rgb_out`=0 and `game_reset`=1.
  - The cycle counter runs 0..RESTART_CYCLES-1, then the state returns to PLAY.
  - If `gameover` is still 1 on return, FADE restarts normally.
- `reset` asserted in any state returns immediately to the reset values.

## Timing
- `rgb_out` is registered: the colour for inputs sampled at edge N appears after edge N, one cycle of latency in every state.
- State change: the PLAY→FADE transition happens on the edge where `gameover`=1 is sampled. Output shading changes from the next cycle.
- Fade duration: 4×FADE_FRAMES_PER_STEP ticks from FADE entry to OVER.
- Press latency: the synchroniser adds 2 cycles and the debounce counter adds DEBOUNCE_CYCLES cycles after the raw input stabilises. Entry to RESTART occurs on the edge that detects the edge of the debounced level.
- `game_reset` rises on the same edge RESTART is entered and stays high exactly RESTART_CYCLES cycles. It is low on the edge the state returns to PLAY.
- Ticks arriving during a single-cycle state transition are consumed by the new state's counters.

## Test plan
- Test parameters: FADE_FRAMES_PER_STEP=2, BLINK_FRAMES=3, RESTART_CYCLES=4, DEBOUNCE_CYCLES=5.
- Compositing: PLAY, `sprite_on`=1/`sprite_rgb`=12'h0AF, then `sprite_on`=0/`background_rgb`=12'hA00, then `video_on`=0 → `rgb_out` 12'h0AF, 12'hA00, 12'h000, each one cycle after its input.
- Fade: assert `gameover` with `c`=12'hFFF → `rgb_out` FFF, 777, 333, 111 for 2 frames each; `state_o`=2 after 8 ticks. Holding x,y at (0,0) for 4 cycles yields 1 tick, not 4.
- Blink: in OVER at pixel (300,240) → F00 for 3 frames, then 400 for 3 frames; pixel (240,200) → FFF; pixel (100,100) → 000.
- Debounce: in OVER, a 3-cycle `btn_start` glitch → no transition. A 10-cycle hold → RESTART, `game_reset` high exactly 4 cycles, then `state_o`=0. A press during PLAY → ignored.
- Reset mid-operation: assert `reset` during FADE level 2 and again during RESTART cycle 1 → all outputs 0 and `state_o`=0 immediately (asynchronously).
